fetch_queue: RTL and testbench
==============================

# fetch_queue

Decode-side receiver for the fetch stage's output. It accepts fetched instruction bundles (InstrD, PCD, PCPlus4D) under a valid/ready handshake and buffers them in a small FIFO, so fetch can run ahead of a stalled decode stage. It presents the oldest bundle to decode under a second valid/ready handshake. The whole queue is discarded when the execute stage redirects the PC via PCSrcE.

## Interface
- DEPTH, 4, number of bundle entries; power of two, ≥ 2
- i_clk  input  1  clock; all state changes on rising edge
- i_rst_n  input  1  synchronous, active-low reset
- i_fetch_valid  input  1  fetch presents a bundle this cycle
- o_fetch_ready  output  1  queue can accept a bundle this cycle
- InstrD  input  32  fetched instruction
- PCD  input  32  PC of the fetched instruction
- PCPlus4D  input  32  PC+4 of the fetched instruction
- PCSrcE  input  1  taken branch/jump resolved in execute; flushes the queue
- o_dec_valid  output  1  head bundle is valid for decode
- i_dec_ready  input  1  decode consumes the head bundle this cycle
- o_InstrQ  output  32  head instruction
- o_PCQ  output  32  head PC
- o_PCPlus4Q  output  32  head PC+4
- o_count  output  $clog2(DEPTH)+1  number of occupied entries

## Operation
- Storage: DEPTH entries × 96 bits {Instr, PC, PCPlus4}.
- Pointers: write pointer and read pointer, each $clog2(DEPTH) bits, wrapping modulo DEPTH. Occupancy is held in a count register of width $clog2(DEPTH)+1.
- Push occurs when i_fetch_valid & o_fetch_ready & ~PCSrcE. The bundle is written at the write pointer, and the write pointer increments.
- Pop occurs when o_dec_valid & i_dec_ready & ~PCSrcE. The read pointer increments.
- Count update:
  - push only: count+1
  - pop only: count−1
  - push and pop together: count unchanged, both pointers advance
- Status and data outputs:
  - o_fetch_ready = i_rst_n & (count != DEPTH). There is no full-bypass: when full, a simultaneous pop does not admit a push in the same cycle.
  - o_dec_valid = (count != 0).
  - o_InstrQ / o_PCQ / o_PCPlus4Q show the head entry when o_dec_valid is 1; otherwise they are forced to 32'b0.
  - o_count equals the count register.
- Flush: PCSrcE=1 at a clock edge sets both pointers and count to 0. In that cycle, any push and pop are suppressed; the offered fetch bundle is dropped and decode does not consume.
- Priority: reset > flush > push/pop.
- Empty with i_dec_ready=1: no effect. Full with i_fetch_valid=1: no write; fetch must hold its bundle.
- Storage contents are not reset; only pointers and count are.

## Timing
- Reset (i_rst_n=0 at a rising edge):
  - pointers and count = 0
  - o_count = 0, o_dec_valid = 0, data outputs = 0
  - o_fetch_ready = 0 while i_rst_n is low, and 1 in the first cycle after release
- Write-to-read latency: 1 cycle. A bundle pushed at edge N is visible on the head outputs after edge N, if the queue was empty.
- No combinational path from i_fetch_valid to o_dec_valid, nor from i_dec_ready to o_fetch_ready.
- Throughput: 1 push and 1 pop per cycle while 0 < count < DEPTH.
- Flush takes effect at the edge where PCSrcE is sampled high. The next cycle shows o_dec_valid=0, o_count=0, o_fetch_ready=1.
- Reset mid-operation clears occupancy at the next edge regardless of handshake activity.

## Test plan
- Reset: hold i_rst_n=0 for 2 cycles with i_fetch_valid=1 → o_fetch_ready=0, o_dec_valid=0, o_count=0, all data outputs 0; after release, o_fetch_ready=1.
- Fill/drain ordering:
  - With i_dec_ready=0, push PCs 0x00, 0x04, 0x08, 0x0C (Instr 0x00000013, PCPlus4 = PC+4) → o_count=4, o_fetch_ready=0.
  - A 5th bundle offered is not accepted.
  - Then set i_dec_ready=1 → head PCs 0x00, 0x04, 0x08, 0x0C on consecutive cycles, then o_dec_valid=0.
- Streaming wrap: continuous push and pop for 20 cycles with PCs 0x100, 0x104, … → o_count stays 1, output order is preserved across pointer wrap, and there are no gaps.
- Full + pop: count=4, i_fetch_valid=1, i_dec_ready=1 → one pop and no push that cycle, count=3; the next cycle accepts the push.
- Flush: count=3, assert PCSrcE=1 with i_fetch_valid=1 and i_dec_ready=1 → next cycle count=0, o_dec_valid=0, and the offered bundle is absent. A subsequent push of PC 0x200 appears as head one cycle later.
- Empty pop: count=0, i_dec_ready=1 for 3 cycles → count stays 0, outputs stay 0, and no pointer movement (the next push appears as head correctly).

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: decode-side FIFO that buffers fetched instruction bundles
// {Instr, PC, PCPlus4} between the fetch and decode handshakes. The whole
// queue is discarded when execute redirects the PC (PCSrcE).
module fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_fetch_valid,
  output logic                     o_fetch_ready,
  input  logic [31:0]              InstrD,
  input  logic [31:0]              PCD,
  input  logic [31:0]              PCPlus4D,
  input  logic                     PCSrcE,
  output logic                     o_dec_valid,
  input  logic                     i_dec_ready,
  output logic [31:0]              o_InstrQ,
  output logic [31:0]              o_PCQ,
  output logic [31:0]              o_PCPlus4Q,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Bundle layout inside one storage word: {Instr, PC, PCPlus4}
  logic [95:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [95:0]      head_word;

  // Status flags derive only from the count register, so neither handshake
  // has a combinational path into the other side's valid/ready.
  always_comb begin
    full          = (count == CNT_W'(DEPTH));
    empty         = (count == '0);
    o_fetch_ready = i_rst_n & ~full;
    o_dec_valid   = ~empty;
    push          = i_fetch_valid & o_fetch_ready & ~PCSrcE;
    pop           = o_dec_valid & i_dec_ready & ~PCSrcE;
  end

  // Storage write; contents are intentionally left unreset
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr] <= {InstrD, PCD, PCPlus4D};
    end
  end

  // Pointer and occupancy update: reset beats flush, flush beats handshakes
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (PCSrcE) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Head presentation; outputs are zeroed whenever the queue is empty
  always_comb begin
    head_word  = mem[rd_ptr];
    o_InstrQ   = 32'b0;
    o_PCQ      = 32'b0;
    o_PCPlus4Q = 32'b0;
    if (o_dec_valid) begin
      o_InstrQ   = head_word[95:64];
      o_PCQ      = head_word[63:32];
      o_PCPlus4Q = head_word[31:0];
    end
    o_count = count;
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: table-driven directed test of fetch_queue plus hand-written
// sequences for streaming wrap and mid-operation reset.
module tb_fetch_queue;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pcp4_d;
  logic        pcsrc_e;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] instr_q;
  logic [31:0] pc_q;
  logic [31:0] pcp4_q;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic        rst_n;
    logic        fv;
    logic [31:0] pc;
    logic        pcsrc;
    logic        dr;
    logic        exp_fr;
    logic        exp_dv;
    logic [2:0]  exp_cnt;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[$];

  fetch_queue #(.DEPTH(4)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_fetch_valid (fetch_valid),
    .o_fetch_ready (fetch_ready),
    .InstrD        (instr_d),
    .PCD           (pc_d),
    .PCPlus4D      (pcp4_d),
    .PCSrcE        (pcsrc_e),
    .o_dec_valid   (dec_valid),
    .i_dec_ready   (dec_ready),
    .o_InstrQ      (instr_q),
    .o_PCQ         (pc_q),
    .o_PCPlus4Q    (pcp4_q),
    .o_count       (count)
  );

  // Free-running clock
  always #5 clk = ~clk;

  function automatic vec_t mk(string name, logic r, logic fv, logic [31:0] pc,
                              logic ps, logic dr, logic efr, logic edv,
                              logic [2:0] ecnt, logic [31:0] epc);
    vec_t v;
    v.name = name; v.rst_n = r; v.fv = fv; v.pc = pc; v.pcsrc = ps; v.dr = dr;
    v.exp_fr = efr; v.exp_dv = edv; v.exp_cnt = ecnt; v.exp_pc = epc;
    return v;
  endfunction

  task automatic compare(string what, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", what, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, then let the rising edge occur
  task automatic applyStimulus(logic r, logic fv, logic [31:0] pc, logic ps, logic dr);
    @(negedge clk);
    rst_n       = r;
    fetch_valid = fv;
    instr_d     = NOP;
    pc_d        = pc;
    pcp4_d      = pc + 32'd4;
    pcsrc_e     = ps;
    dec_ready   = dr;
    @(posedge clk);
    #1;
  endtask

  // Compare every output against the expected post-edge state
  task automatic checkOutput(string name, logic efr, logic edv, logic [2:0] ecnt,
                             logic [31:0] epc);
    compare({name, ".fetch_ready"}, {31'b0, fetch_ready}, {31'b0, efr});
    compare({name, ".dec_valid"}, {31'b0, dec_valid}, {31'b0, edv});
    compare({name, ".count"}, {29'b0, count}, {29'b0, ecnt});
    compare({name, ".instr"}, instr_q, edv ? NOP : 32'b0);
    compare({name, ".pc"}, pc_q, edv ? epc : 32'b0);
    compare({name, ".pcplus4"}, pcp4_q, edv ? epc + 32'd4 : 32'b0);
  endtask

  initial begin
    rst_n = 1'b0; fetch_valid = 1'b0; instr_d = '0; pc_d = '0; pcp4_d = '0;
    pcsrc_e = 1'b0; dec_ready = 1'b0;

    //            name        rst fv  pc        fl  dr  fr  dv  cnt  head pc
    vecs.push_back(mk("rst0",   0, 1, 32'h040, 0, 0, 0, 0, 3'd0, 32'h0));
    vecs.push_back(mk("rst1",   0, 1, 32'h040, 0, 0, 0, 0, 3'd0, 32'h0));
    vecs.push_back(mk("rel",    1, 0, 32'h000, 0, 0, 1, 0, 3'd0, 32'h0));
    vecs.push_back(mk("fill0",  1, 1, 32'h000, 0, 0, 1, 1, 3'd1, 32'h000));
    vecs.push_back(mk("fill1",  1, 1, 32'h004, 0, 0, 1, 1, 3'd2, 32'h000));
    vecs.push_back(mk("fill2",  1, 1, 32'h008, 0, 0, 1, 1, 3'd3, 32'h000));
    vecs.push_back(mk("fill3",  1, 1, 32'h00C, 0, 0, 0, 1, 3'd4, 32'h000));
    vecs.push_back(mk("fifth",  1, 1, 32'h010, 0, 0, 0, 1, 3'd4, 32'h000));
    vecs.push_back(mk("drain0", 1, 0, 32'h000, 0, 1, 1, 1, 3'd3, 32'h004));
    vecs.push_back(mk("drain1", 1, 0, 32'h000, 0, 1, 1, 1, 3'd2, 32'h008));
    vecs.push_back(mk("drain2", 1, 0, 32'h000, 0, 1, 1, 1, 3'd1, 32'h00C));
    vecs.push_back(mk("drain3", 1, 0, 32'h000, 0, 1, 1, 0, 3'd0, 32'h0));
    vecs.push_back(mk("refil0", 1, 1, 32'h020, 0, 0, 1, 1, 3'd1, 32'h020));
    vecs.push_back(mk("refil1", 1, 1, 32'h024, 0, 0, 1, 1, 3'd2, 32'h020));
    vecs.push_back(mk("refil2", 1, 1, 32'h028, 0, 0, 1, 1, 3'd3, 32'h020));
    vecs.push_back(mk("refil3", 1, 1, 32'h02C, 0, 0, 0, 1, 3'd4, 32'h020));
    vecs.push_back(mk("fullpp", 1, 1, 32'h030, 0, 1, 1, 1, 3'd3, 32'h024));
    vecs.push_back(mk("afterp", 1, 1, 32'h030, 0, 0, 0, 1, 3'd4, 32'h024));
    vecs.push_back(mk("to3",    1, 0, 32'h000, 0, 1, 1, 1, 3'd3, 32'h028));
    vecs.push_back(mk("flush",  1, 1, 32'h034, 1, 1, 1, 0, 3'd0, 32'h0));
    vecs.push_back(mk("pfl200", 1, 1, 32'h200, 0, 0, 1, 1, 3'd1, 32'h200));
    vecs.push_back(mk("pfl_dr", 1, 0, 32'h000, 0, 1, 1, 0, 3'd0, 32'h0));
    vecs.push_back(mk("epop0",  1, 0, 32'h000, 0, 1, 1, 0, 3'd0, 32'h0));
    vecs.push_back(mk("epop1",  1, 0, 32'h000, 0, 1, 1, 0, 3'd0, 32'h0));
    vecs.push_back(mk("epop2",  1, 0, 32'h000, 0, 1, 1, 0, 3'd0, 32'h0));
    vecs.push_back(mk("ep300",  1, 1, 32'h300, 0, 0, 1, 1, 3'd1, 32'h300));
    vecs.push_back(mk("ep_dr",  1, 0, 32'h000, 0, 1, 1, 0, 3'd0, 32'h0));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst_n, vecs[i].fv, vecs[i].pc, vecs[i].pcsrc, vecs[i].dr);
      checkOutput(vecs[i].name, vecs[i].exp_fr, vecs[i].exp_dv, vecs[i].exp_cnt,
                  vecs[i].exp_pc);
    end

    // Streaming: one entry preloaded, then simultaneous push/pop across wrap
    applyStimulus(1, 1, 32'h100, 0, 0);
    checkOutput("stream_pre", 1, 1, 3'd1, 32'h100);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, 1, 32'h104 + 32'(4 * i), 0, 1);
      checkOutput($sformatf("stream%0d", i), 1, 1, 3'd1, 32'h104 + 32'(4 * i));
    end
    applyStimulus(1, 0, 32'h0, 0, 1);
    checkOutput("stream_end", 1, 0, 3'd0, 32'h0);

    // Reset in the middle of activity clears occupancy despite handshakes
    applyStimulus(1, 1, 32'h400, 0, 0);
    applyStimulus(1, 1, 32'h404, 0, 0);
    checkOutput("mid_pre", 1, 1, 3'd2, 32'h400);
    applyStimulus(0, 1, 32'h408, 0, 1);
    checkOutput("mid_rst", 0, 0, 3'd0, 32'h0);
    applyStimulus(1, 1, 32'h500, 0, 0);
    checkOutput("mid_rel", 1, 1, 3'd1, 32'h500);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
